logic_probe_sequencer: RTL

//   Runs logic-probe measurement windows. Loads DAC threshold codes, waits for analog settling,

---
 rtl/logic_probe_pkg.sv | 35 +++
 rtl/logic_probe_sequencer_sync.sv | 28 ++
 rtl/logic_probe_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/logic_probe_pkg.sv
// Shared types for the logic-probe sequencer: FSM states, comparator level codes
// and the comparator-pair classifier.
package logic_probe_pkg;

  localparam int DAC_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    MEASURE,
    LATCH
  } state_t;

  typedef enum logic [1:0] {
    LVL_LOW  = 2'd0,
    LVL_MID  = 2'd1,
    LVL_HIGH = 2'd2,
    LVL_ERR  = 2'd3
  } level_t;

  // hi means "above the high threshold", lo means "below the low threshold";
  // both at once is physically inconsistent and is reported as an error level.
  function automatic level_t classify(input logic hi, input logic lo);
    level_t lvl;
    case ({hi, lo})
      2'b10:   lvl = LVL_HIGH;
      2'b01:   lvl = LVL_LOW;
      2'b00:   lvl = LVL_MID;
      default: lvl = LVL_ERR;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/logic_probe_sequencer_sync.sv
// Brings the two asynchronous comparator outputs into the clk domain and
// classifies the synchronized pair into a level code (2-cycle latency).
module probe_level_sync
  import logic_probe_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       comp_hi,
  input  logic       comp_lo,
  output logic [1:0] level
);

  logic [1:0] hi_sync;
  logic [1:0] lo_sync;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hi_sync <= '0;
      lo_sync <= '0;
    end else begin
      hi_sync <= {hi_sync[0], comp_hi};
      lo_sync <= {lo_sync[0], comp_lo};
    end
  end

  assign level = classify(hi_sync[1], lo_sync[1]);

endmodule

// File: rtl/logic_probe_sequencer.sv
// Measurement-window sequencer: loads DAC thresholds, waits for settling, then
// counts HIGH/LOW/MID cycles and rising pulses over a fixed window.
module logic_probe_sequencer
  import logic_probe_pkg::*;
#(
  parameter int TIME_PERIOD   = 5000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [DAC_WIDTH-1:0] thr_hi_cfg,
  input  logic [DAC_WIDTH-1:0] thr_lo_cfg,
  input  logic                 comp_out_hi,
  input  logic                 comp_out_lo,
  output logic [DAC_WIDTH-1:0] dac1_code,
  output logic [DAC_WIDTH-1:0] dac2_code,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] res_high,
  output logic [CNT_WIDTH-1:0] res_low,
  output logic [CNT_WIDTH-1:0] res_mid,
  output logic [CNT_WIDTH-1:0] res_pulses,
  output logic                 res_err
);

  localparam int PH_MAX = (TIME_PERIOD > SETTLE_CYCLES) ? TIME_PERIOD : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0] SETTLE_LAST  = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] MEASURE_LAST = PH_W'(TIME_PERIOD - 1);

  state_t               state;
  state_t               state_nx;
  logic [PH_W-1:0]      phase;
  logic [1:0]           level;
  logic [1:0]           prev_level;
  logic [CNT_WIDTH-1:0] cnt_high;
  logic [CNT_WIDTH-1:0] cnt_low;
  logic [CNT_WIDTH-1:0] cnt_mid;
  logic [CNT_WIDTH-1:0] cnt_pulses;
  logic                 cnt_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  probe_level_sync u_sync (
    .clk     (clk),
    .nreset  (nreset),
    .comp_hi (comp_out_hi),
    .comp_lo (comp_out_lo),
    .level   (level)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  // abort overrides every transition, including LATCH and a simultaneous start.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = LOAD;
        LOAD:    state_nx = SETTLE;
        SETTLE:  if (phase == SETTLE_LAST) state_nx = MEASURE;
        MEASURE: if (phase == MEASURE_LAST) state_nx = LATCH;
        LATCH:   state_nx = continuous ? LOAD : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase <= '0;
    end else if (state_nx != state) begin
      phase <= '0;
    end else if (state == SETTLE || state == MEASURE) begin
      phase <= phase + 1'b1;
    end
  end

  // An aborting cycle performs none of the state's actions, so DAC codes and
  // results keep whatever they held before the abort.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dac1_code  <= '0;
      dac2_code  <= '0;
      cnt_high   <= '0;
      cnt_low    <= '0;
      cnt_mid    <= '0;
      cnt_pulses <= '0;
      cnt_err    <= 1'b0;
      prev_level <= LVL_MID;
      res_high   <= '0;
      res_low    <= '0;
      res_mid    <= '0;
      res_pulses <= '0;
      res_err    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!abort) begin
        case (state)
          LOAD: begin
            dac1_code  <= thr_hi_cfg;
            dac2_code  <= thr_lo_cfg;
            cnt_high   <= '0;
            cnt_low    <= '0;
            cnt_mid    <= '0;
            cnt_pulses <= '0;
            cnt_err    <= 1'b0;
            prev_level <= level;
          end
          MEASURE: begin
            case (level)
              LVL_HIGH: cnt_high <= sat_inc(cnt_high);
              LVL_LOW:  cnt_low  <= sat_inc(cnt_low);
              LVL_MID:  cnt_mid  <= sat_inc(cnt_mid);
              default:  cnt_err  <= 1'b1;
            endcase
            if (level == LVL_HIGH && prev_level != LVL_HIGH)
              cnt_pulses <= sat_inc(cnt_pulses);
            if (level != LVL_ERR)
              prev_level <= level;
          end
          LATCH: begin
            res_high   <= cnt_high;
            res_low    <= cnt_low;
            res_mid    <= cnt_mid;
            res_pulses <= cnt_pulses;
            res_err    <= cnt_err;
            done       <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
